// File: rtl/alu_muldiv_iterativa.sv
// alu_muldiv_iterativa: iterative RV32M multiply/divide unit with START/BUSY/DONE handshake.
// Define FAST_MUL_EN to resolve the multiply ops with one combinational multiplier in a single step.
module alu_muldiv_iterativa #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       CONTROL,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] RESULTADO,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state;
  logic [2:0] op;
  logic neg_q, neg_r, spec;
  logic [WIDTH-1:0] a, d, quo, rem, spec_res;
  logic [2*WIDTH:0] prod;
  logic [CW-1:0] cnt;
  logic sx, sy, xn, yn, dz, ovf, is_spec;
  logic [WIDTH-1:0] mx, my, spec_val, qv, rv, res;
  logic [WIDTH:0] sum, sh, diff;
  logic [2*WIDTH-1:0] pm;
  // Signedness per operand: multiply follows MUL/MULH/MULHSU/MULHU, divide follows bit 0.
  assign sx = CONTROL[2] ? !CONTROL[0] : CONTROL[1:0] != 2'b11;
  assign sy = CONTROL[2] ? !CONTROL[0] : !CONTROL[1];
  assign xn = sx & X[WIDTH-1];
  assign yn = sy & Y[WIDTH-1];
  assign mx = xn ? -X : X;
  assign my = yn ? -Y : Y;
  assign dz = CONTROL[2] & (Y == '0);
  assign ovf = CONTROL[2] & !CONTROL[0] & (X == MIN) & (Y == '1);
`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fx, fy, fp;
  assign fx = {{WIDTH{xn}}, X};
  assign fy = {{WIDTH{yn}}, Y};
  assign fp = fx * fy;
  assign is_spec = !CONTROL[2] | dz | ovf;
  assign spec_val = !CONTROL[2] ? (CONTROL[1:0] == 2'b00 ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH]) :
                    dz ? (CONTROL[1] ? X : '1) : (CONTROL[1] ? '0 : X);
`else
  assign is_spec = dz | ovf;
  assign spec_val = dz ? (CONTROL[1] ? X : '1) : (CONTROL[1] ? '0 : X);
`endif
  assign sum = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, a} : '0);
  assign sh = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, d};
  assign pm = neg_q ? -prod[2*WIDTH-1:0] : prod[2*WIDTH-1:0];
  assign qv = neg_q ? -quo : quo;
  assign rv = neg_r ? -rem : rem;
  assign res = spec ? spec_res :
               op[2] ? (op[1] ? rv : qv) :
               (op[1:0] == 2'b00 ? pm[WIDTH-1:0] : pm[2*WIDTH-1:WIDTH]);
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
      op <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      spec <= 1'b0;
      a <= '0;
      d <= '0;
      quo <= '0;
      rem <= '0;
      spec_res <= '0;
      prod <= '0;
      cnt <= '0;
      RESULTADO <= '0;
      ZERO <= 1'b1;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          op <= CONTROL;
          neg_q <= xn ^ yn;
          neg_r <= xn;
          a <= mx;
          d <= my;
          quo <= mx;
          rem <= '0;
          prod <= {{(WIDTH+1){1'b0}}, my};
          cnt <= '0;
          spec <= is_spec;
          spec_res <= spec_val;
          BUSY <= 1'b1;
          state <= is_spec ? FIN : CALC;
        end
        CALC: begin
          if (op[2]) begin
            rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
          end else
            prod <= {sum, prod[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FIN;
        end
        FIN: begin
          RESULTADO <= res;
          ZERO <= res == '0;
          DONE <= 1'b1;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_iterativa.sv
// tb_alu_muldiv_iterativa: directed self-checking bench for alu_muldiv_iterativa (WIDTH=32).
module tb_alu_muldiv_iterativa;
  logic CLK = 1'b0;
  logic RESET_N, START, ZERO, BUSY, DONE;
  logic [2:0] CONTROL;
  logic [31:0] X, Y, RESULTADO;
  int checks = 0;
  int errors = 0;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  alu_muldiv_iterativa #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .CONTROL(CONTROL), .X(X), .Y(Y),
    .RESULTADO(RESULTADO), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  task automatic do_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output int lat);
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b1;
    CONTROL = c;
    X = x;
    Y = y;
    @(posedge CLK);
    #1;
    START = 1'b0;
    CONTROL = ~c;
    X = ~x;
    Y = y + 32'd1;
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!DONE && lat < 100);
    r = RESULTADO;
    z = ZERO;
  endtask
  task automatic test_reset;
    RESET_N = 1'b0;
    START = 1'b0;
    CONTROL = 3'd0;
    X = 32'd0;
    Y = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (RESULTADO !== 32'd0 || ZERO !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset: res=%h zero=%b busy=%b done=%b, need 0/1/0/0", RESULTADO, ZERO, BUSY, DONE);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask
  task automatic test_mul;
    logic [31:0] r;
    logic z;
    int lat;
    do_op(3'b000, 32'd7, 32'hFFFFFFFD, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFEB || z !== 1'b0) begin
      errors++;
      $display("FAIL mul_7x-3: got %h z=%b, need ffffffeb z=0", r, z);
    end
    checks++;
    if (lat !== MUL_LAT) begin
      errors++;
      $display("FAIL mul_latency: got %0d, need %0d", lat, MUL_LAT);
    end
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL mulhu: got %h, need fffffffe", r);
    end
    do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, lat);
    checks++;
    if (r !== 32'h00000000 || z !== 1'b1) begin
      errors++;
      $display("FAIL mulh: got %h z=%b, need 00000000 z=1", r, z);
    end
    do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mulhsu: got %h, need ffffffff", r);
    end
    do_op(3'b001, 32'h40000000, 32'h00000010, r, z, lat);
    checks++;
    if (r !== 32'h00000004) begin
      errors++;
      $display("FAIL mulh_pos: got %h, need 00000004", r);
    end
  endtask
  task automatic test_div;
    logic [31:0] r;
    logic z;
    int lat;
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFFD || lat !== 33) begin
      errors++;
      $display("FAIL div_-7/2: got %h lat=%0d, need fffffffd lat=33", r, lat);
    end
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rem_-7/2: got %h, need ffffffff", r);
    end
    do_op(3'b101, 32'd100, 32'd7, r, z, lat);
    checks++;
    if (r !== 32'd14) begin
      errors++;
      $display("FAIL divu_100/7: got %0d, need 14", r);
    end
    do_op(3'b111, 32'd100, 32'd7, r, z, lat);
    checks++;
    if (r !== 32'd2) begin
      errors++;
      $display("FAIL remu_100/7: got %0d, need 2", r);
    end
    do_op(3'b110, 32'd7, 32'hFFFFFFFE, r, z, lat);
    checks++;
    if (r !== 32'd1) begin
      errors++;
      $display("FAIL rem_7/-2: got %h, need 00000001", r);
    end
  endtask
  task automatic test_special;
    logic [31:0] r;
    logic z;
    int lat;
    do_op(3'b101, 32'd5, 32'd0, r, z, lat);
    checks++;
    if (r !== 32'hFFFFFFFF || lat !== 1) begin
      errors++;
      $display("FAIL divu_by0: got %h lat=%0d, need ffffffff lat=1", r, lat);
    end
    do_op(3'b110, 32'd5, 32'd0, r, z, lat);
    checks++;
    if (r !== 32'd5 || lat !== 1) begin
      errors++;
      $display("FAIL rem_by0: got %h lat=%0d, need 5 lat=1", r, lat);
    end
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
    checks++;
    if (r !== 32'h80000000 || lat !== 1) begin
      errors++;
      $display("FAIL div_ovf: got %h lat=%0d, need 80000000 lat=1", r, lat);
    end
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
    checks++;
    if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL rem_ovf: got %h z=%b lat=%0d, need 0 z=1 lat=1", r, z, lat);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] r, first;
    logic z, busy_seen;
    int lat, dones;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b1;
    CONTROL = 3'b101;
    X = 32'd100;
    Y = 32'd7;
    dones = 0;
    first = 32'd0;
    busy_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      START = (i == 5);
      if (i == 5) begin
        CONTROL = 3'b000;
        X = 32'd9;
        Y = 32'd9;
        busy_seen = BUSY;
      end
      if (DONE) begin
        if (dones == 0) first = RESULTADO;
        dones++;
      end
      if (dones == 1 && DONE) break;
    end
    START = 1'b0;
    checks++;
    if (busy_seen !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b, need 1", busy_seen);
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 1 || first !== 32'd14) begin
      errors++;
      $display("FAIL b2b_ignore: dones=%0d res=%0d, need 1 and 14", dones, first);
    end
    do_op(3'b000, 32'd6, 32'd7, r, z, lat);
    checks++;
    if (r !== 32'd42 || lat !== MUL_LAT) begin
      errors++;
      $display("FAIL b2b_next: got %0d lat=%0d, need 42 lat=%0d", r, lat, MUL_LAT);
    end
  endtask
  task automatic test_reset_abort;
    logic [31:0] r;
    logic z;
    int lat, dones;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b1;
    CONTROL = 3'b101;
    X = 32'd1000;
    Y = 32'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0 || RESULTADO !== 32'd0 || ZERO !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b res=%h zero=%b done=%b, need 0/0/1/0", BUSY, RESULTADO, ZERO, DONE);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_nodone: got %0d DONE pulses, need 0", dones);
    end
    do_op(3'b000, 32'd3, 32'd4, r, z, lat);
    checks++;
    if (r !== 32'd12 || z !== 1'b0) begin
      errors++;
      $display("FAIL after_abort_mul: got %0d z=%b, need 12 z=0", r, z);
    end
  endtask
  initial begin
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
